twod_ppc_retx_ctrl: RTL and testbench

TWOD_PPC_RETX_CTRL -- requirements
Module: twod_ppc_retx_ctrl

---
 rtl/twod_ppc_retx_ctrl_pkg.sv | 19 +
 rtl/twod_ppc_retx_ctrl_if.sv | 25 ++
 rtl/twod_ppc_replay_buf.sv | 21 ++
 rtl/twod_ppc_retx_ctrl.sv | 104 ++++++++++
 tb/tb_twod_ppc_retx_ctrl.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/twod_ppc_retx_ctrl_pkg.sv
// Shared types and sizing helpers for the 2D-parity retransmission slice.
package twod_ppc_pkg;

   localparam int unsigned DATA_W_DEF = 16;
   localparam int unsigned CODE_W_DEF = 25;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SEND,
      ST_WAIT,
      ST_ERROR
   } state_t;

   // One extra bit so that full and empty have distinct pointer differences.
   function automatic int unsigned ptr_w(input int unsigned depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/twod_ppc_retx_ctrl_if.sv
// Upstream flit handshake plus link launch/response signals of the retx controller.
interface twod_ppc_retx_ctrl_if
   import twod_ppc_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned CODE_W = CODE_W_DEF
);
   logic              in_valid;
   logic [DATA_W-1:0] in_data;
   logic              in_ready;
   logic              link_valid;
   logic [CODE_W-1:0] link_code;
   logic              rsp_valid;
   logic              rsp_nack;

   modport master (
      input  in_valid, in_data, rsp_valid, rsp_nack,
      output in_ready, link_valid, link_code
   );

   modport slave (
      output in_valid, in_data, rsp_valid, rsp_nack,
      input  in_ready, link_valid, link_code
   );
endinterface

// File: rtl/twod_ppc_replay_buf.sv
// Replay storage: one synchronous write port, one asynchronous read port.
module twod_ppc_replay_buf #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned DEPTH  = 4,
   localparam int unsigned AW    = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [AW-1:0]     wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [AW-1:0]     rd_addr,
   output logic [DATA_W-1:0] rd_data
);
   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   assign rd_data = mem[rd_addr];
endmodule

// File: rtl/twod_ppc_retx_ctrl.sv
// Go-back-N retransmission controller feeding an external 2D-parity encoder;
// flits stay buffered until ACKed, a NACK rewinds launch to the oldest unacked flit.
module twod_ppc_retx_ctrl
   import twod_ppc_pkg::*;
#(
   parameter int unsigned DATA_W    = DATA_W_DEF,
   parameter int unsigned CODE_W    = CODE_W_DEF,
   parameter int unsigned DEPTH     = 4,
   parameter int unsigned MAX_RETRY = 3
) (
   input  logic                 clk,
   input  logic                 reset,
   twod_ppc_retx_ctrl_if.master bus,
   output logic [DATA_W-1:0]    enc_data,
   output logic                 enc_nack,
   input  logic [CODE_W-1:0]    enc_code,
   input  logic                 enc_f,
   output logic                 err
);
   localparam int unsigned PW = ptr_w(DEPTH);
   localparam int unsigned AW = PW - 1;
   localparam int unsigned RW = $clog2(MAX_RETRY + 1);

   state_t            state, state_n;
   logic [PW-1:0]     wr_ptr, ack_ptr, snd_ptr;
   logic [PW-1:0]     wr_ptr_n, ack_ptr_n, snd_ptr_n;
   logic [PW-1:0]     occ, outstanding;
   logic [RW-1:0]     retry_cnt, retry_cnt_n;
   logic              live, accept, launch, ack, nack;
   logic              link_valid_q;
   logic [CODE_W-1:0] link_code_q;

   assign occ         = wr_ptr - ack_ptr;
   assign outstanding = snd_ptr - ack_ptr;
   assign live        = (state != ST_ERROR);

   assign bus.in_ready = !reset && live && (occ < PW'(DEPTH));
   assign accept       = bus.in_valid && bus.in_ready;
   assign enc_nack     = bus.rsp_valid && bus.rsp_nack;
   assign ack          = live && bus.rsp_valid && !bus.rsp_nack && (outstanding != '0);
   assign nack         = live && enc_nack && (outstanding != '0);
   // enc_f already covers the NACK cycle; nack is repeated so the rewind wins regardless
   assign launch       = (state == ST_SEND) && (snd_ptr != wr_ptr) && !enc_f && !nack;

   assign err            = (state == ST_ERROR);
   assign bus.link_valid = link_valid_q;
   assign bus.link_code  = link_code_q;

   twod_ppc_replay_buf #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_buf (
      .clk     (clk),
      .wr_en   (accept),
      .wr_addr (wr_ptr[AW-1:0]),
      .wr_data (bus.in_data),
      .rd_addr (snd_ptr[AW-1:0]),
      .rd_data (enc_data)
   );

   always_comb begin
      wr_ptr_n    = wr_ptr + PW'(accept);
      ack_ptr_n   = ack ? ack_ptr + PW'(1) : ack_ptr;
      snd_ptr_n   = snd_ptr;
      retry_cnt_n = retry_cnt;
      state_n     = state;
      if (nack) begin
         snd_ptr_n   = ack_ptr;
         retry_cnt_n = retry_cnt + RW'(1);
      end else if (launch) begin
         snd_ptr_n = snd_ptr + PW'(1);
      end
      if (ack) retry_cnt_n = '0;
      // State follows the next pointers, so IDLE/SEND/WAIT always agree with them.
      if (!live || (nack && (retry_cnt_n >= RW'(MAX_RETRY))))
         state_n = ST_ERROR;
      else if (snd_ptr_n != wr_ptr_n)
         state_n = ST_SEND;
      else if (wr_ptr_n != ack_ptr_n)
         state_n = ST_WAIT;
      else
         state_n = ST_IDLE;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= ST_IDLE;
         wr_ptr       <= '0;
         ack_ptr      <= '0;
         snd_ptr      <= '0;
         retry_cnt    <= '0;
         link_valid_q <= 1'b0;
         link_code_q  <= '0;
      end else begin
         state        <= state_n;
         wr_ptr       <= wr_ptr_n;
         ack_ptr      <= ack_ptr_n;
         snd_ptr      <= snd_ptr_n;
         retry_cnt    <= retry_cnt_n;
         link_valid_q <= launch;
         if (launch) link_code_q <= enc_code;
      end
   end
endmodule

// File: tb/tb_twod_ppc_retx_ctrl.sv
// Self-checking bench for twod_ppc_retx_ctrl: directed table, corner sequences,
// and random traffic against a queue-based reference model.
module tb_twod_ppc_retx_ctrl;
   import twod_ppc_pkg::*;

   localparam int DEPTH     = 4;
   localparam int MAX_RETRY = 3;

   logic        clk = 1'b0;
   logic        reset;
   logic        fault;
   logic [15:0] enc_data;
   logic        enc_nack;
   logic [24:0] enc_code;
   logic        enc_f;
   logic        err;

   always #5 clk = ~clk;

   twod_ppc_retx_ctrl_if #(.DATA_W(16), .CODE_W(25)) bus ();

   twod_ppc_retx_ctrl #(
      .DATA_W    (16),
      .CODE_W    (25),
      .DEPTH     (DEPTH),
      .MAX_RETRY (MAX_RETRY)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .bus      (bus),
      .enc_data (enc_data),
      .enc_nack (enc_nack),
      .enc_code (enc_code),
      .enc_f    (enc_f),
      .err      (err)
   );

   // 4x4 data array plus row parities, column parities and corner bit.
   function automatic logic [24:0] enc2d(input logic [15:0] d);
      logic [24:0] c;
      c = '0;
      for (int r = 0; r < 4; r++)
         for (int k = 0; k < 4; k++) begin
            c[r*5+k] = d[r*4+k];
            c[r*5+4] = c[r*5+4] ^ d[r*4+k];
            c[20+k]  = c[20+k] ^ d[r*4+k];
            c[24]    = c[24] ^ d[r*4+k];
         end
      return c;
   endfunction

   assign enc_code = enc2d(enc_data);
   assign enc_f    = fault | enc_nack;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: queue of unacked flits, count launched, consecutive NACKs.
   logic [15:0] mq[$];
   int          m_sent;
   int          m_retry;
   bit          m_err;
   bit          m_lv;
   logic [24:0] m_code;
   logic [24:0] lq[$];
   logic        s_rdy, s_lv, s_err;

   task automatic model_clear();
      mq.delete();
      m_sent = 0; m_retry = 0; m_err = 0; m_lv = 0; m_code = '0;
   endtask

   task automatic cyc(input logic r, input logic iv, input logic [15:0] d,
                      input logic rv, input logic rn, input logic f);
      bit exp_rdy, nk, ak, ef, launch;
      reset = r; bus.in_valid = iv; bus.in_data = d;
      bus.rsp_valid = rv; bus.rsp_nack = rn; fault = f;
      #1;
      exp_rdy = !r && !m_err && (mq.size() < DEPTH);
      s_rdy = bus.in_ready; s_lv = bus.link_valid; s_err = err;
      chk("in_ready", {31'd0, bus.in_ready}, {31'd0, exp_rdy});
      chk("link_valid", {31'd0, bus.link_valid}, {31'd0, m_lv});
      if (m_lv) chk("link_code", {7'd0, bus.link_code}, {7'd0, m_code});
      chk("err", {31'd0, err}, {31'd0, m_err});
      chk("enc_nack", {31'd0, enc_nack}, {31'd0, rv && rn});
      if (!m_err && m_sent < mq.size()) chk("enc_data", {16'd0, enc_data}, {16'd0, mq[m_sent]});
      if (bus.link_valid) lq.push_back(bus.link_code);
      if (r) begin
         model_clear();
      end else begin
         nk = rv && rn && (m_sent > 0) && !m_err;
         ak = rv && !rn && (m_sent > 0) && !m_err;
         ef = f || (rv && rn);
         launch = !m_err && (m_sent < mq.size()) && !ef && !nk;
         m_lv = launch;
         if (launch) m_code = enc2d(mq[m_sent]);
         if (ak) begin
            void'(mq.pop_front());
            m_sent--;
            m_retry = 0;
         end
         if (nk) begin
            m_sent = 0;
            m_retry++;
            if (m_retry >= MAX_RETRY) m_err = 1;
         end
         if (launch) m_sent++;
         if (iv && exp_rdy) mq.push_back(d);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(0, 0, 16'h0, 0, 0, 0);
   endtask

   typedef struct packed {
      logic        rst;
      logic        iv;
      logic [15:0] d;
      logic        rv;
      logic        rn;
      logic        f;
      logic        e_rdy;
      logic        e_lv;
      logic        e_err;
   } vec_t;

   vec_t tbl[$];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic r, iv, rv, rn, f;
      reset = 1'b1; fault = 1'b0;
      bus.in_valid = 1'b0; bus.in_data = '0; bus.rsp_valid = 1'b0; bus.rsp_nack = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      model_clear();

      // Single flit A5C3 with late ACK, then a flit held back by encoder faults.
      tbl.push_back('{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
      tbl.push_back('{1'b0, 1'b1, 16'hA5C3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
      tbl.push_back('{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
      tbl.push_back('{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0});
      tbl.push_back('{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
      tbl.push_back('{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
      tbl.push_back('{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
      tbl.push_back('{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
      tbl.push_back('{1'b0, 1'b1, 16'hB00F, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
      tbl.push_back('{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0});
      tbl.push_back('{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0});
      tbl.push_back('{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
      tbl.push_back('{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0});
      tbl.push_back('{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
      tbl.push_back('{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
      tbl.push_back('{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
      lq.delete();
      foreach (tbl[i]) begin
         cyc(tbl[i].rst, tbl[i].iv, tbl[i].d, tbl[i].rv, tbl[i].rn, tbl[i].f);
         chk($sformatf("tbl%0d_rdy", i), {31'd0, s_rdy}, {31'd0, tbl[i].e_rdy});
         chk($sformatf("tbl%0d_lv", i), {31'd0, s_lv}, {31'd0, tbl[i].e_lv});
         chk($sformatf("tbl%0d_err", i), {31'd0, s_err}, {31'd0, tbl[i].e_err});
      end
      chk("tbl_codes", lq.size(), 2);
      if (lq.size() == 2) begin
         chk("tbl_code_a5c3", {7'd0, lq[0]}, {7'd0, enc2d(16'hA5C3)});
         chk("tbl_code_b00f", {7'd0, lq[1]}, {7'd0, enc2d(16'hB00F)});
      end
      chk("tbl_idle", {31'd0, dut.state == ST_IDLE}, 32'd1);

      // Fill to DEPTH back-to-back; fifth flit waits until one ACK frees a slot.
      cyc(1, 0, 16'h0, 0, 0, 0);
      for (int i = 0; i < 4; i++) cyc(0, 1, 16'h1000 + 16'(i), 0, 0, 0);
      for (int i = 0; i < 4; i++) begin
         cyc(0, 1, 16'h2005, 0, 0, 0);
         chk("full_rdy", {31'd0, s_rdy}, 32'd0);
      end
      cyc(0, 1, 16'h2005, 1, 0, 0);
      chk("full_ack_rdy", {31'd0, s_rdy}, 32'd0);
      cyc(0, 1, 16'h2005, 0, 0, 0);
      chk("freed_rdy", {31'd0, s_rdy}, 32'd1);
      cyc(0, 0, 16'h0, 0, 0, 0);
      chk("refull_rdy", {31'd0, s_rdy}, 32'd0);
      for (int i = 0; i < 4; i++) cyc(0, 0, 16'h0, 1, 0, 0);
      idle(2);
      chk("drain_occ", {29'd0, dut.occ}, 32'd0);

      // NACK on flit 1 of three in flight: go-back-N relaunch 1,2,3.
      cyc(1, 0, 16'h0, 0, 0, 0);
      lq.delete();
      for (int i = 1; i <= 3; i++) cyc(0, 1, 16'(i), 0, 0, 0);
      idle(3);
      cyc(0, 0, 16'h0, 1, 1, 0);
      idle(6);
      for (int i = 0; i < 3; i++) cyc(0, 0, 16'h0, 1, 0, 0);
      idle(2);
      chk("gbn_launch_count", lq.size(), 6);
      for (int k = 0; k < 6 && k < lq.size(); k++)
         chk($sformatf("gbn_order%0d", k), {7'd0, lq[k]}, {7'd0, enc2d(16'((k % 3) + 1))});
      chk("gbn_occ", {29'd0, dut.occ}, 32'd0);
      chk("gbn_rdy", {31'd0, bus.in_ready}, 32'd1);

      // Three consecutive NACKs on one flit reach the retry limit.
      cyc(1, 0, 16'h0, 0, 0, 0);
      cyc(0, 1, 16'h3C3C, 0, 0, 0);
      for (int n = 0; n < 3; n++) begin
         idle(3);
         cyc(0, 0, 16'h0, 1, 1, 0);
      end
      for (int i = 0; i < 6; i++) begin
         cyc(0, 1, 16'($urandom), 1'($urandom), 1'($urandom), 0);
         chk("errst_err", {31'd0, s_err}, 32'd1);
         chk("errst_rdy", {31'd0, s_rdy}, 32'd0);
         chk("errst_lv", {31'd0, s_lv}, 32'd0);
      end
      cyc(1, 0, 16'h0, 0, 0, 0);
      cyc(0, 0, 16'h0, 0, 0, 0);
      chk("errclr_err", {31'd0, s_err}, 32'd0);
      chk("errclr_rdy", {31'd0, s_rdy}, 32'd1);

      // Reset with two flits outstanding, then a spurious ACK.
      cyc(1, 0, 16'h0, 0, 0, 0);
      cyc(0, 1, 16'h7777, 0, 0, 0);
      cyc(0, 1, 16'h8888, 0, 0, 0);
      idle(2);
      cyc(1, 0, 16'h0, 0, 0, 0);
      for (int i = 0; i < 6; i++) begin
         cyc(0, 0, 16'h0, i == 1, 0, 0);
         chk("rstmid_lv", {31'd0, s_lv}, 32'd0);
      end
      chk("rstmid_occ", {29'd0, dut.occ}, 32'd0);
      chk("rstmid_ackptr", {29'd0, dut.ack_ptr}, 32'd0);
      chk("rstmid_rdy", {31'd0, bus.in_ready}, 32'd1);

      // Random traffic against the model.
      cyc(1, 0, 16'h0, 0, 0, 0);
      for (int i = 0; i < 3000; i++) begin
         r  = ($urandom % 150 == 0) || (m_err && ($urandom % 8 == 0));
         iv = 1'($urandom % 2);
         rv = (m_sent > 0) ? ($urandom % 100 < 35) : ($urandom % 100 < 5);
         rn = ($urandom % 100 < 20);
         f  = ($urandom % 100 < 10);
         cyc(r, iv, 16'($urandom), rv, rn, f);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
